// File: rtl/proc_inst_driver.sv
// Host-side instruction issuer for the 4-bit register/ALU core: buffers a short program,
// plays each word onto the core pins for HOLD cycles and captures {zero, result} per word.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | accepting loads/clear, waiting for start
// S_ISSUE  | driving prog[pc] on o_inst_out, sampling on last hold cycle
// S_FINISH | one-cycle done pulse, then back to idle
module proc_inst_driver #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int HOLD  = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load_valid,
  input  logic [15:0]   i_load_data,
  output logic          o_load_ready,
  input  logic          i_clear,
  input  logic          i_start,
  output logic          o_busy,
  output logic          o_done,
  output logic [AW:0]   o_prog_count,
  output logic [15:0]   o_inst_out,
  output logic          o_inst_valid,
  input  logic [7:0]    i_res_in,
  input  logic          i_zero_in,
  input  logic [AW-1:0] i_res_addr,
  output logic [8:0]    o_res_data,
  output logic          o_err_zero
);

  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  logic [1:0]    r_state;
  logic [15:0]   r_prog [DEPTH];
  logic [8:0]    r_res  [DEPTH];
  logic [AW:0]   r_count;
  logic [AW-1:0] r_pc;
  logic [HW-1:0] r_hold;
  logic          r_busy;
  logic          r_done;
  logic [15:0]   r_inst_out;
  logic          r_inst_valid;
  logic [8:0]    r_res_data;
  logic          r_err_zero;

  logic          w_idle;
  logic          w_accept;
  logic          w_last_hold;
  logic          w_last_word;
  logic          w_zero_bad;
  logic [AW-1:0] w_pc_next;

  assign w_idle       = (r_state == S_IDLE);
  assign o_load_ready = w_idle && (r_count < (AW+1)'(DEPTH));
  // clear takes priority over a simultaneous load
  assign w_accept     = o_load_ready && i_load_valid && !i_clear;
  assign w_last_hold  = (r_hold == HW'(HOLD - 1));
  assign w_last_word  = ({1'b0, r_pc} == (r_count - (AW+1)'(1)));
  assign w_zero_bad   = i_zero_in != (i_res_in == 8'h00);
  assign w_pc_next    = r_pc + AW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_count      <= '0;
      r_pc         <= '0;
      r_hold       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_inst_out   <= 16'h0000;
      r_inst_valid <= 1'b0;
      r_res_data   <= '0;
      r_err_zero   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_prog[i] <= '0;
        r_res[i]  <= '0;
      end
    end else begin
      r_done     <= 1'b0;
      r_res_data <= r_res[i_res_addr];
      case (r_state)
        S_IDLE: begin
          if (i_clear) begin
            r_count    <= '0;
            r_err_zero <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_res[i] <= '0;
          end else begin
            if (w_accept) begin
              r_prog[r_count[AW-1:0]] <= i_load_data;
              r_count                 <= r_count + (AW+1)'(1);
            end
            if (i_start) begin
              if (r_count != '0) begin
                r_state      <= S_ISSUE;
                r_pc         <= '0;
                r_hold       <= '0;
                r_busy       <= 1'b1;
                r_inst_out   <= r_prog[0];
                r_inst_valid <= 1'b1;
              end else begin
                r_state <= S_FINISH;
                r_done  <= 1'b1;
              end
            end
          end
        end
        S_ISSUE: begin
          if (w_last_hold) begin
            r_res[r_pc] <= {i_zero_in, i_res_in};
            if (w_zero_bad) r_err_zero <= 1'b1;
            if (w_last_word) begin
              r_state      <= S_FINISH;
              r_done       <= 1'b1;
              r_busy       <= 1'b0;
              r_inst_out   <= 16'h0000;
              r_inst_valid <= 1'b0;
            end else begin
              r_pc       <= w_pc_next;
              r_hold     <= '0;
              r_inst_out <= r_prog[w_pc_next];
            end
          end else begin
            r_hold <= r_hold + HW'(1);
          end
        end
        S_FINISH: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_prog_count = r_count;
  assign o_inst_out   = r_inst_out;
  assign o_inst_valid = r_inst_valid;
  assign o_res_data   = r_res_data;
  assign o_err_zero   = r_err_zero;

endmodule

// File: tb/tb_proc_inst_driver.sv
// Directed bench for proc_inst_driver with a combinational core stub that either returns
// a fixed result or echoes the low byte of the issued word (optionally corrupting one word).
module tb_proc_inst_driver;

  logic        clk;
  logic        rst_n;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready;
  logic        clear;
  logic        start;
  logic        busy;
  logic        done;
  logic [3:0]  prog_count;
  logic [15:0] inst_out;
  logic        inst_valid;
  logic [7:0]  res_in;
  logic        zero_in;
  logic [2:0]  res_addr;
  logic [8:0]  res_data;
  logic        err_zero;

  logic        stub_fixed;
  logic [7:0]  fix_res;
  logic        fix_zero;
  logic [15:0] bad_word;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  lows [9];
  logic [15:0] words [9];
  logic [15:0] w3 [3];
  logic [15:0] w5 [5];

  proc_inst_driver #(.DEPTH(8), .AW(3), .HOLD(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load_valid (load_valid),
    .i_load_data  (load_data),
    .o_load_ready (load_ready),
    .i_clear      (clear),
    .i_start      (start),
    .o_busy       (busy),
    .o_done       (done),
    .o_prog_count (prog_count),
    .o_inst_out   (inst_out),
    .o_inst_valid (inst_valid),
    .i_res_in     (res_in),
    .i_zero_in    (zero_in),
    .i_res_addr   (res_addr),
    .o_res_data   (res_data),
    .o_err_zero   (err_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    res_in  = 8'h00;
    zero_in = 1'b0;
    if (stub_fixed) begin
      res_in  = fix_res;
      zero_in = fix_zero;
    end else if (inst_valid && inst_out == bad_word) begin
      res_in  = 8'h00;
      zero_in = 1'b0;
    end else begin
      res_in  = inst_out[7:0];
      zero_in = (inst_out[7:0] == 8'h00);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic load_word(input logic [15:0] w);
    load_valid = 1'b1;
    load_data  = w;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; load_valid = 1'b0; load_data = 16'h0; clear = 1'b0; start = 1'b0;
    res_addr = 3'd0; stub_fixed = 1'b1; fix_res = 8'h00; fix_zero = 1'b0; bad_word = 16'hFFFF;
    lows = '{8'h11, 8'h22, 8'h00, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
    for (int i = 0; i < 9; i++) words[i] = {8'h80 | 8'(i), lows[i]};
    w3 = '{16'h0101, 16'h0202, 16'h0303};
    w5 = '{16'h1A01, 16'h1A02, 16'h1A03, 16'h1A04, 16'h1A05};

    #2;
    chk("rst_inst_out", inst_out, 16'h0000);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_prog_count", prog_count, 0);
    chk("rst_err_zero", err_zero, 0);
    #1 rst_n = 1'b1;
    tick();

    // single add instruction, fixed stub result 0x05
    fix_res = 8'h05; fix_zero = 1'b0;
    chk("t1_load_ready", load_ready, 1);
    load_word(16'h09B0);
    chk("t1_prog_count", prog_count, 1);
    start = 1'b1; tick(); start = 1'b0;
    chk("t1_inst_c0", inst_out, 16'h09B0);
    chk("t1_valid_c0", inst_valid, 1);
    chk("t1_busy_c0", busy, 1);
    tick();
    chk("t1_inst_c1", inst_out, 16'h09B0);
    chk("t1_done_c1", done, 0);
    tick();
    chk("t1_done", done, 1);
    chk("t1_inst_fin", inst_out, 16'h0000);
    chk("t1_valid_fin", inst_valid, 0);
    tick();
    chk("t1_done_off", done, 0);
    res_addr = 3'd0; tick();
    chk("t1_res0", res_data, 9'h005);
    chk("t1_err", err_zero, 0);

    // fill past capacity, then run with echo stub
    stub_fixed = 1'b0;
    do_clear();
    chk("t2_cleared", prog_count, 0);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("t2_ready%0d", i), load_ready, (i < 8) ? 1 : 0);
      load_word(words[i]);
    end
    chk("t2_prog_count", prog_count, 8);
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 16; c++) begin
      chk($sformatf("t2_inst_c%0d", c), inst_out, words[c/2]);
      chk($sformatf("t2_valid_c%0d", c), inst_valid, 1);
      tick();
    end
    chk("t2_done", done, 1);
    chk("t2_valid_end", inst_valid, 0);
    for (int i = 0; i < 8; i++) begin
      res_addr = 3'(i); tick();
      chk($sformatf("t2_res%0d", i), res_data, {(lows[i] == 8'h00), lows[i]});
    end
    chk("t2_err", err_zero, 0);

    // empty program
    do_clear();
    start = 1'b1; tick(); start = 1'b0;
    chk("t3_done", done, 1);
    chk("t3_busy", busy, 0);
    chk("t3_valid", inst_valid, 0);
    tick();
    chk("t3_done_off", done, 0);
    chk("t3_valid2", inst_valid, 0);
    res_addr = 3'd3; tick();
    chk("t3_res_cleared", res_data, 9'h000);

    // inconsistent zero flag on second word
    bad_word = 16'h0202;
    for (int i = 0; i < 3; i++) load_word(w3[i]);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    chk("t4_inst_w1", inst_out, 16'h0202);
    chk("t4_err_before", err_zero, 0);
    tick();
    chk("t4_err_rise", err_zero, 1);
    chk("t4_inst_w2", inst_out, 16'h0303);
    tick(); tick();
    chk("t4_done", done, 1);
    chk("t4_err_sticky", err_zero, 1);
    res_addr = 3'd1; tick();
    chk("t4_res1", res_data, 9'h000);
    do_clear();
    chk("t4_err_cleared", err_zero, 0);
    bad_word = 16'hFFFF;

    // start and load attempts during a run
    for (int i = 0; i < 3; i++) load_word(w3[i]);
    start = 1'b1; tick(); start = 1'b0;
    load_valid = 1'b1; load_data = 16'hDEAD;
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("t6_inst_c%0d", c), inst_out, w3[c/2]);
      chk($sformatf("t6_ready_c%0d", c), load_ready, 0);
      start = (c == 2);
      tick();
    end
    start = 1'b0;
    chk("t6_done", done, 1);
    chk("t6_prog_count", prog_count, 3);
    load_valid = 1'b0;
    tick();
    chk("t6_no_restart", inst_valid, 0);

    // async reset during the third word of five
    do_clear();
    for (int i = 0; i < 5; i++) load_word(w5[i]);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick(); tick();
    chk("t5_inst_w2", inst_out, 16'h1A03);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_inst", inst_out, 16'h0000);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_count", prog_count, 0);
    #1 rst_n = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    chk("t5_empty_done", done, 1);
    chk("t5_empty_valid", inst_valid, 0);
    tick();
    chk("t5_empty_valid2", inst_valid, 0);
    chk("t5_empty_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/proc_inst_driver.md
Name: proc_inst_driver

Overview:
Host-side issuer for the 4-bit register/ALU processor core. It buffers a short program of 16-bit instruction words and, on start, drives them one at a time onto the core's instruction pins. Each word is held for a fixed number of cycles. The block samples the core's 8-bit result and zero flag into a result buffer that the host reads back. It sits between the test/host logic and the processor pins: instruction word bits [7:0] go to ui_in and bits [15:8] go to uio_in; uo_out and uio_out[0] come back as results.

Parameters:
DEPTH, 8, number of program/result entries (power of two, 2..16)
AW, 3, log2(DEPTH)
HOLD, 2, cycles each instruction is held on inst_out (>=1); result sampled in the last hold cycle

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
load_valid  in  1  host presents a program word
load_data  in  16  instruction word {regw[15:13], reg1[12:10], reg2[9:7], func[6:3], opcode[2:0]}
load_ready  out  1  word accepted on load_valid&load_ready
clear  in  1  pulse: empty program and results (ignored while busy)
start  in  1  pulse: begin issuing stored program
busy  out  1  high from cycle after start until done
done  out  1  one-cycle pulse after last result captured
prog_count  out  AW+1  number of stored program words
inst_out  out  16  instruction driven to core pins
inst_valid  out  1  high while inst_out carries a program word
res_in  in  8  core ALU result (uo_out)
zero_in  in  1  core zero flag (uio_out[0])
res_addr  in  AW  result read index
res_data  out  9  {zero, result} at res_addr, registered, 1-cycle latency
err_zero  out  1  sticky: sampled zero_in != (res_in==0)

Behaviour:
- Reset: all outputs 0, including inst_out=16'h0000 (opcode 000, non-writing NOP), prog_count=0, FSM=IDLE. Program and result storage are cleared. Reset mid-run aborts immediately and discards the program.
- load_ready = (state==IDLE) & (prog_count<DEPTH). An accepted word is written at index prog_count, and prog_count increments by 1. When full, load_ready=0 and extra words are dropped with no side effects.
- clear in IDLE: prog_count<=0, err_zero<=0, result entries<=0. If clear and load_valid are asserted in the same cycle, clear wins and the word is dropped.
- FSM:
  - IDLE --start & prog_count>0--> ISSUE. pc<=0, hold<=0, busy<=1.
  - IDLE --start & prog_count==0--> FINISH. No instruction is issued.
  - ISSUE: inst_out=prog[pc], inst_valid=1, hold counts 0..HOLD-1.
    - When hold==HOLD-1: result[pc]<={zero_in,res_in}, and err_zero is set if zero_in != (res_in==8'h00).
    - Then, if pc==prog_count-1, go to FINISH; else pc++ and hold<=0. The next word appears on the following cycle with no gap.
  - FINISH: done=1 for exactly one cycle, busy<=0, inst_out<=0, inst_valid<=0, then IDLE.
- start while busy or in FINISH is ignored. Loads are refused while not in IDLE.
- inst_out and inst_valid are registered: the first word appears the cycle after start. Total run length is prog_count*HOLD cycles of inst_valid, then one FINISH cycle.
- res_data is registered from result[res_addr] every cycle, regardless of state. A read of the entry being written in the same cycle returns the old value.
- The program buffer is preserved after a run; start may reissue it without reloading.
- Result entries at indices >= prog_count keep their prior contents.

Test Plan:
- Reset, then load 16'h09B0 (reg1=2, reg2=3, func=0110 add, opcode 000). Core stub returns res_in=8'h05, zero_in=0. Pulse start. Required: inst_out=16'h09B0 for exactly 2 cycles starting 1 cycle after start; done pulses 1 cycle later; reading res_addr=0 gives 9'h005; err_zero=0.
- Load DEPTH+1=9 words. Required: load_ready drops after the 8th acceptance, prog_count=8, the 9th word is ignored. Then run with the stub echoing inst_out[7:0] as result. Required: 16 inst_valid cycles, and results 0..7 match the low bytes of the loaded words.
- Start with an empty program. Required: done pulses 1 cycle after start, inst_valid never asserts, busy stays 0 or drops after one cycle.
- Stub drives res_in=8'h00 with zero_in=0 on the second word. Required: err_zero rises in that word's sample cycle and stays high until clear.
- Assert rst_n low mid-run during the third word of a five-word program. Required: inst_out=0, busy=0, prog_count=0 asynchronously; the following start issues nothing.
- Pulse start during a run, and assert load_valid during a run. Required: no restart, load_ready=0, and the original sequence completes unchanged.
